mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one unified memory port between the CPU and a DMA/loader engine.
// Each requester uses a req/ack handshake; the arbiter grants one requester
// at a time with round-robin fairness, drives the memory port from latched
// request registers, waits for mem_ready and aborts hung accesses after
// TIMEOUT busy cycles with an error-qualified ack.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata      CPU request (req held until cpu_ack)
//   cpu_rdata/ack/err          CPU response (ack/err one-cycle pulses)
//   dma_*                      same set for the DMA requester
//   mem_en/we/addr/wdata       memory request, stable for a whole access
//   mem_rdata, mem_ready       memory response
//   busy                       high while an access is in progress
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | no access; arbitrate between eligible reqs
// CPU_BUSY | memory port owned by the CPU
// DMA_BUSY | memory port owned by the DMA engine

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          dma_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    localparam int            CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CPU_BUSY,
        DMA_BUSY
    } state_t;

    state_t        state;
    logic          last_cpu;   // 1: last grant went to the CPU
    logic [CW-1:0] tcnt;       // busy cycles elapsed without mem_ready

    logic cpu_elig, dma_elig, grant_cpu, grant_dma;

    // A requester in its ack cycle still has req high for the old access;
    // masking it stops that stale request from being granted again.
    assign cpu_elig  = cpu_req & ~cpu_ack;
    assign dma_elig  = dma_req & ~dma_ack;
    assign grant_cpu = cpu_elig & (~dma_elig | ~last_cpu);
    assign grant_dma = dma_elig & (~cpu_elig |  last_cpu);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_cpu  <= 1'b0;
            tcnt      <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            dma_ack   <= 1'b0;
            dma_err   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            dma_ack <= 1'b0;
            dma_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        state     <= CPU_BUSY;
                        last_cpu  <= 1'b1;
                        tcnt      <= '0;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                    end else if (grant_dma) begin
                        state     <= DMA_BUSY;
                        last_cpu  <= 1'b0;
                        tcnt      <= '0;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        mem_we    <= dma_we;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                    end
                end
                CPU_BUSY, DMA_BUSY: begin
                    if (mem_ready || tcnt == TC) begin
                        // success, or abort on the TIMEOUT-th silent cycle
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        if (state == CPU_BUSY) begin
                            cpu_ack   <= 1'b1;
                            cpu_err   <= ~mem_ready;
                            cpu_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            dma_ack   <= 1'b1;
                            dma_err   <= ~mem_ready;
                            dma_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (AW=DW=32, TIMEOUT=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic        mem_ready = 0;
    logic        cpu_ack, cpu_err, dma_ack, dma_err, mem_en, mem_we, busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .dma_err(dma_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        cyc(); cyc();
        reset = 1'b0;

        // ---- single CPU read
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        cyc();
        chk("rd_busy", busy, 1);
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 32'h40);
        chk("rd_ack_early", cpu_ack, 0);
        mem_ready = 1; mem_rdata = 32'h1234ABCD;
        cyc();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_err", cpu_err, 0);
        chk("rd_rdata", cpu_rdata, 32'h1234ABCD);
        chk("rd_idle", busy, 0);
        cpu_req = 0; mem_ready = 0;
        cyc();
        chk("rd_ack_pulse", cpu_ack, 0);
        chk("rd_rdata_hold", cpu_rdata, 32'h1234ABCD);

        // ---- tie and round-robin from reset
        reset = 1; #1;
        chk("rst2_rdata", cpu_rdata, 0);
        cyc();
        reset = 0;
        cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        mem_ready = 1; mem_rdata = 32'h55;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk($sformatf("rr_en_c%0d", c), mem_en, 32'(c % 2));
            if (c % 2 == 1)
                chk($sformatf("rr_addr_c%0d", c), mem_addr,
                    (c == 1 || c == 5) ? 32'h10 : 32'h20);
            chk($sformatf("rr_cack_c%0d", c), cpu_ack, 32'(c == 2 || c == 6));
            chk($sformatf("rr_dack_c%0d", c), dma_ack, 32'(c == 4 || c == 8));
        end
        chk("rr_drdata", dma_rdata, 32'h55);
        cpu_req = 0; dma_req = 0; mem_ready = 0;
        cyc();

        // ---- DMA write with wait states (last grant was DMA, DMA alone first)
        dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hCAFEF00D;
        cpu_addr = 32'h44;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            cpu_req = 1;
            chk($sformatf("wr_busy_c%0d", c), busy, 1);
            chk($sformatf("wr_we_c%0d", c), mem_we, 1);
            chk($sformatf("wr_addr_c%0d", c), mem_addr, 32'h100);
            chk($sformatf("wr_wdata_c%0d", c), mem_wdata, 32'hCAFEF00D);
            chk($sformatf("wr_cack_c%0d", c), cpu_ack, 0);
            chk($sformatf("wr_dack_c%0d", c), dma_ack, 0);
            if (c == 4) mem_ready = 1;
        end
        cyc();
        chk("wr_dack", dma_ack, 1);
        chk("wr_derr", dma_err, 0);
        chk("wr_idle", mem_en, 0);
        dma_req = 0; dma_we = 0;
        cyc();
        chk("wr_cpu_grant", mem_addr, 32'h44);
        chk("wr_cpu_busy", busy, 1);
        cpu_req = 0;
        cyc();
        chk("wr_cpu_ack", cpu_ack, 1);
        mem_ready = 0;
        cyc();

        // ---- timeout abort
        cpu_req = 1; cpu_addr = 32'h80;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            chk($sformatf("to_busy_c%0d", c), busy, 1);
            chk($sformatf("to_ack_c%0d", c), cpu_ack, 0);
        end
        cyc();
        chk("to_ack", cpu_ack, 1);
        chk("to_err", cpu_err, 1);
        chk("to_rdata", cpu_rdata, 0);
        chk("to_idle", busy, 0);
        cpu_req = 0;
        cyc();
        // next access is normal; mem_ready in IDLE is ignored
        cpu_req = 1; mem_ready = 1; mem_rdata = 32'h77;
        cyc();
        chk("nx_busy", busy, 1);
        cyc();
        chk("nx_ack", cpu_ack, 1);
        chk("nx_err", cpu_err, 0);
        chk("nx_rdata", cpu_rdata, 32'h77);
        cpu_req = 0; mem_ready = 0;
        cyc();
        // mem_ready in the 16th busy cycle still succeeds
        cpu_req = 1;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            chk($sformatf("bd_busy_c%0d", c), busy, 1);
            chk($sformatf("bd_ack_c%0d", c), cpu_ack, 0);
        end
        mem_ready = 1; mem_rdata = 32'h9999;
        cyc();
        chk("bd_ack", cpu_ack, 1);
        chk("bd_err", cpu_err, 0);
        chk("bd_rdata", cpu_rdata, 32'h9999);
        cpu_req = 0; mem_ready = 0;
        cyc();

        // ---- reset mid-access
        cpu_req = 1; cpu_addr = 32'h200;
        cyc();
        chk("mr_busy1", busy, 1);
        cyc();
        chk("mr_busy2", busy, 1);
        #2 reset = 1;
        #1;
        chk("mr_mem_en", mem_en, 0);
        chk("mr_busy", busy, 0);
        chk("mr_mem_addr", mem_addr, 0);
        chk("mr_cpu_rdata", cpu_rdata, 0);
        chk("mr_dma_rdata", dma_rdata, 0);
        cpu_req = 0;
        cyc(); cyc();
        reset = 0;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk($sformatf("mr_noack_c%0d", c), cpu_ack, 0);
        end
        cpu_req = 1; cpu_addr = 32'h300; dma_req = 1; dma_addr = 32'h400; mem_ready = 1;
        cyc();
        chk("mr_tie_cpu", mem_addr, 32'h300);
        dma_req = 0;

        // ---- ack-cycle ignore: cpu_req held through its ack cycle
        cyc();
        chk("ai_ack", cpu_ack, 1);
        cyc();
        chk("ai_no_regrant", mem_en, 0);
        cyc();
        chk("ai_regrant", mem_en, 1);
        chk("ai_regrant_addr", mem_addr, 32'h300);
        cpu_req = 0;
        cyc();
        chk("ai_ack2", cpu_ack, 1);
        mem_ready = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
